// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM serviced after a fixed LATENCY, one mem_resp pulse per request.
// Optional DMEM_RANGE_CHECK_EN adds mem_err and drops out-of-range writes.
module dmem_responder #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_mbe,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
`ifdef DMEM_RANGE_CHECK_EN
  output logic        mem_err,
`endif
  output logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, oor_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [3:0]         mbe_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [2**ADDR_W];

  logic               req, acc, enter_resp, commit, oor_in;
  logic               cur_wr, cur_oor;
  logic [ADDR_W-1:0]  cur_idx;
  logic [3:0]         cur_mbe;
  logic [31:0]        cur_wdata;

`ifdef DMEM_RANGE_CHECK_EN
  assign oor_in = |mem_address[31:ADDR_W+2];
  logic unused_addr;
  assign unused_addr = ^mem_address[1:0];
`else
  assign oor_in = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{mem_address[31:ADDR_W+2], mem_address[1:0]};
`endif

  assign req = mem_read | mem_write;
  assign acc = (state_q == IDLE) && req;

  // With LATENCY=1 the acceptance edge is also the RESP-entry edge, so the
  // live inputs are used there; otherwise the latched copy is.
  always_comb begin
    if (state_q == IDLE) begin
      cur_wr    = mem_write;
      cur_oor   = oor_in;
      cur_idx   = mem_address[ADDR_W+1:2];
      cur_mbe   = mem_mbe;
      cur_wdata = mem_wdata;
    end else begin
      cur_wr    = wr_q;
      cur_oor   = oor_q;
      cur_idx   = idx_q;
      cur_mbe   = mbe_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (LATENCY == 1) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);
  assign commit     = enter_resp && cur_wr && !cur_oor && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      mbe_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        wr_q    <= mem_write;
        oor_q   <= oor_in;
        idx_q   <= mem_address[ADDR_W+1:2];
        mbe_q   <= mem_mbe;
        wdata_q <= mem_wdata;
      end
    end
  end

  // Array has no reset; rst gating in commit keeps aborted writes out.
  always_ff @(posedge clk) begin
    if (commit)
      for (int b = 0; b < 4; b++)
        if (cur_mbe[b]) mem_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
  end

  // Read samples the pre-write word, so read+write returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rdata_q <= '0;
    else if (enter_resp) rdata_q <= cur_oor ? 32'h0 : mem_q[cur_idx];
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_rdata = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign mem_err   = (state_q == RESP) && oor_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 0, mem_write = 0;
  logic [3:0]  mem_mbe = 0;
  logic [31:0] mem_address = 0, mem_wdata = 0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        b_read = 0;
  logic        b_resp;
  logic [31:0] b_rdata;
`ifdef DMEM_RANGE_CHECK_EN
  logic        mem_err, b_err;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_mbe(mem_mbe), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp),
`ifdef DMEM_RANGE_CHECK_EN
    .mem_err(mem_err),
`endif
    .mem_rdata(mem_rdata));

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(b_read), .mem_write(1'b0),
    .mem_mbe(4'h0), .mem_address(32'h0), .mem_wdata(32'h0),
    .mem_resp(b_resp),
`ifdef DMEM_RANGE_CHECK_EN
    .mem_err(b_err),
`endif
    .mem_rdata(b_rdata));

  int n_chk = 0, n_pass = 0;
  logic [31:0] mdl [1024];
  bit          known [1024];
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One transaction: latency, read data vs model, single pulse, rdata hold.
  task automatic xact(input string tag, input logic r, input logic w, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rdo);
    int n = 0;
    int idx = int'(addr[11:2]);
    bit oor = 0;
    logic [31:0] exp_rd;
`ifdef DMEM_RANGE_CHECK_EN
    oor = |addr[31:12];
`endif
    exp_rd = oor ? 32'h0 : mdl[idx];
    @(negedge clk);
    mem_read = r; mem_write = w; mem_mbe = be; mem_address = addr; mem_wdata = wd;
    do begin @(posedge clk); #1; n++; end while (!mem_resp && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    rdo = mem_rdata;
    if (r && (oor || known[idx])) chk({tag, "_rdata"}, mem_rdata, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
    chk({tag, "_err"}, {31'h0, mem_err}, {31'h0, oor});
`endif
    mem_read = 0; mem_write = 0;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'h0, mem_resp}, 32'h0);
    chk({tag, "_hold"}, mem_rdata, rdo);
    if (w && !oor) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      if (be == 4'hF) known[idx] = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mdl[i] = 0; known[i] = 0; end
    #12;
    chk("rst_resp", {31'h0, mem_resp}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(negedge clk); rst = 0;

    xact("w40", 0, 1, 4'hF, 32'h40, 32'h11223344, rd);
    xact("w100", 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, rd);
    xact("r100", 1, 0, 4'h0, 32'h100, 32'h0, rd);
    chk("r100_const", rd, 32'hDEADBEEF);

    xact("w8", 0, 1, 4'hF, 32'h8, 32'hAABBCCDD, rd);
    xact("w8b", 0, 1, 4'b0100, 32'h8, 32'h00550000, rd);
    xact("r8", 1, 0, 4'hF, 32'h8, 32'h0, rd);
    chk("r8_const", rd, 32'hAA55CCDD);
    xact("w8z", 0, 1, 4'h0, 32'h8, 32'hFFFFFFFF, rd);
    xact("r8z", 1, 0, 4'h0, 32'h8, 32'h0, rd);
    chk("r8z_const", rd, 32'hAA55CCDD);

    xact("w20", 0, 1, 4'hF, 32'h20, 32'h1, rd);
    xact("rw20", 1, 1, 4'hF, 32'h20, 32'h2, rd);
    chk("rw20_const", rd, 32'h1);
    xact("r20", 1, 0, 4'h0, 32'h20, 32'h0, rd);
    chk("r20_const", rd, 32'h2);

    // Reset during WAIT of a write: aborted, nothing committed.
    @(negedge clk);
    mem_write = 1; mem_mbe = 4'hF; mem_address = 32'h20; mem_wdata = 32'h99;
    @(posedge clk); #1;
    rst = 1; #1;
    chk("rstw_resp", {31'h0, mem_resp}, 32'h0);
    chk("rstw_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    chk("rstw_resp2", {31'h0, mem_resp}, 32'h0);
    mem_write = 0;
    @(negedge clk); rst = 0;
    xact("r20b", 1, 0, 4'h0, 32'h20, 32'h0, rd);
    chk("r20b_const", rd, 32'h2);
    xact("r40", 1, 0, 4'h0, 32'h40, 32'h0, rd);
    chk("r40_const", rd, 32'h11223344);

    xact("w0", 0, 1, 4'hF, 32'h0, 32'h0BADF00D, rd);
    xact("w1000", 0, 1, 4'hF, 32'h00001000, 32'h12345678, rd);
    xact("r0", 1, 0, 4'h0, 32'h0, 32'h0, rd);
`ifdef DMEM_RANGE_CHECK_EN
    chk("r0_const", rd, 32'h0BADF00D);
`else
    chk("r0_alias", rd, 32'h12345678);
`endif

    for (int i = 0; i < 8; i++)
      xact("init", 0, 1, 4'hF, 32'((512 + i) * 4), $urandom, rd);
    for (int i = 0; i < 60; i++) begin
      int op = $urandom_range(0, 2);
      logic [31:0] a = 32'(((512 + $urandom_range(0, 7)) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
      xact("rnd", op != 1, op != 0, 4'($urandom), a, $urandom, rd);
    end

    // LATENCY=1 with read held: pulse every other cycle, never adjacent.
    @(negedge clk); b_read = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("b2b", {31'h0, b_resp}, {31'h0, k[0]});
    end
    b_read = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
